// File: rtl/iir_mac_sequencer.sv
// rtl/iir_mac_sequencer.sv - MAC sequencing FSM for a 2nd-order DF-II IIR filter (optional IIR_OVERRUN_EN)
module iir_mac_sequencer #(
  parameter int MAC_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ovr_clr,
  output logic [2:0] bar1,
  output logic [1:0] bar2,
  output logic [1:0] bar3,
  output logic       ld_acum,
  output logic       ld_fk,
  output logic       shift_hist,
  output logic       ld_y,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A1,
    S_A2,
    S_FK,
    S_B0,
    S_B1,
    S_B2,
    S_OUT
  } state_t;

  localparam logic [3:0] LAT = 4'(MAC_LAT);

  // select codes used while no operand is needed
  localparam logic [2:0] B1_ZERO = 3'd5;
  localparam logic [1:0] B2_ZERO = 2'd3;
  localparam logic [1:0] B3_ZERO = 2'd2;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;

  logic [2:0] bar1_n;
  logic [1:0] bar2_n;
  logic [1:0] bar3_n;
  logic       ld_acum_n;
  logic       ld_fk_n;
  logic       shift_hist_n;
  logic       ld_y_n;
  logic       busy_n;
  logic       done_n;
  logic       mac_last_n;

  // next state and hold counter: MAC states sit for 1+MAC_LAT cycles, leaving when cnt hits 0
  always_comb begin
    state_n = state;
    cnt_n   = 4'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_A1;
          cnt_n   = LAT;
        end
      end
      S_A1: begin
        if (cnt == 4'd0) begin
          state_n = S_A2;
          cnt_n   = LAT;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_A2: begin
        if (cnt == 4'd0) begin
          state_n = S_FK;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_FK: begin
        state_n = S_B0;
        cnt_n   = LAT;
      end
      S_B0: begin
        if (cnt == 4'd0) begin
          state_n = S_B1;
          cnt_n   = LAT;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_B1: begin
        if (cnt == 4'd0) begin
          state_n = S_B2;
          cnt_n   = LAT;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_B2: begin
        if (cnt == 4'd0) begin
          state_n = S_OUT;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_OUT: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // decode the outputs of the state being entered so they can be registered alongside it
  always_comb begin
    bar1_n       = B1_ZERO;
    bar2_n       = B2_ZERO;
    bar3_n       = B3_ZERO;
    ld_acum_n    = 1'b0;
    ld_fk_n      = 1'b0;
    shift_hist_n = 1'b0;
    ld_y_n       = 1'b0;
    done_n       = 1'b0;
    busy_n       = (state_n != S_IDLE);
    mac_last_n   = (cnt_n == 4'd0);
    case (state_n)
      S_A1: begin
        bar1_n    = 3'd0;
        bar2_n    = 2'd1;
        bar3_n    = 2'd0;
        ld_acum_n = mac_last_n;
      end
      S_A2: begin
        bar1_n    = 3'd1;
        bar2_n    = 2'd2;
        bar3_n    = 2'd1;
        ld_acum_n = mac_last_n;
      end
      S_FK: begin
        ld_fk_n = 1'b1;
      end
      S_B0: begin
        bar1_n    = 3'd2;
        bar2_n    = 2'd0;
        bar3_n    = 2'd2;
        ld_acum_n = mac_last_n;
      end
      S_B1: begin
        bar1_n    = 3'd3;
        bar2_n    = 2'd1;
        bar3_n    = 2'd1;
        ld_acum_n = mac_last_n;
      end
      S_B2: begin
        bar1_n    = 3'd4;
        bar2_n    = 2'd2;
        bar3_n    = 2'd1;
        ld_acum_n = mac_last_n;
      end
      S_OUT: begin
        ld_y_n       = 1'b1;
        shift_hist_n = 1'b1;
        done_n       = 1'b1;
      end
      default: begin
        bar1_n = B1_ZERO;
      end
    endcase
  end

  // state register with registered Moore outputs; reset drops any coincident start
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      bar1       <= B1_ZERO;
      bar2       <= B2_ZERO;
      bar3       <= B3_ZERO;
      ld_acum    <= 1'b0;
      ld_fk      <= 1'b0;
      shift_hist <= 1'b0;
      ld_y       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bar1       <= bar1_n;
      bar2       <= bar2_n;
      bar3       <= bar3_n;
      ld_acum    <= ld_acum_n;
      ld_fk      <= ld_fk_n;
      shift_hist <= shift_hist_n;
      ld_y       <= ld_y_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

`ifdef IIR_OVERRUN_EN
  // sticky overrun: a start seen outside IDLE sets it, and setting beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (start && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// tb/tb_iir_mac_sequencer.sv - scoreboard bench for iir_mac_sequencer at MAC_LAT 0 and 2
module tb_iir_mac_sequencer;

`ifdef IIR_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  // {bar1,bar2,bar3,ld_acum,ld_fk,shift_hist,ld_y,busy,done,overrun}
  localparam logic [13:0] IDLE_V = {3'd5, 2'd3, 2'd2, 7'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ovr_clr = 1'b0;

  logic [2:0] bar1_0, bar1_1;
  logic [1:0] bar2_0, bar2_1, bar3_0, bar3_1;
  logic ld_acum_0, ld_fk_0, shift_hist_0, ld_y_0, busy_0, done_0, overrun_0;
  logic ld_acum_1, ld_fk_1, shift_hist_1, ld_y_1, busy_1, done_1, overrun_1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [13:0] expq0[$];
  logic [13:0] expq1[$];

  logic [13:0] cur[2];
  logic [13:0] pend[2][0:31];
  int          plen[2];
  int          pidx[2];
  logic        ovr[2];

  always #5 clk = ~clk;

  iir_mac_sequencer #(.MAC_LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .ovr_clr(ovr_clr),
    .bar1(bar1_0), .bar2(bar2_0), .bar3(bar3_0),
    .ld_acum(ld_acum_0), .ld_fk(ld_fk_0), .shift_hist(shift_hist_0), .ld_y(ld_y_0),
    .busy(busy_0), .done(done_0), .overrun(overrun_0)
  );

  iir_mac_sequencer #(.MAC_LAT(2)) u1 (
    .clk(clk), .reset(reset), .start(start), .ovr_clr(ovr_clr),
    .bar1(bar1_1), .bar2(bar2_1), .bar3(bar3_1),
    .ld_acum(ld_acum_1), .ld_fk(ld_fk_1), .shift_hist(shift_hist_1), .ld_y(ld_y_1),
    .busy(busy_1), .done(done_1), .overrun(overrun_1)
  );

  wire [13:0] act0 = {bar1_0, bar2_0, bar3_0, ld_acum_0, ld_fk_0, shift_hist_0, ld_y_0,
                      busy_0, done_0, overrun_0};
  wire [13:0] act1 = {bar1_1, bar2_1, bar3_1, ld_acum_1, ld_fk_1, shift_hist_1, ld_y_1,
                      busy_1, done_1, overrun_1};

  // expected outputs k cycles into a sample run: seven phases, MAC phases last lat+1 cycles
  function automatic logic [13:0] run_vec(input int lat, input int k);
    int m, base, dur, p;
    logic last, found;
    logic [13:0] v;
    m = lat + 1;
    base = 0;
    p = 6;
    last = 1'b1;
    found = 1'b0;
    for (int q = 0; q < 7; q++) begin
      dur = (q == 2 || q == 6) ? 1 : m;
      if (!found && k < base + dur) begin
        p = q;
        last = (k == base + dur - 1);
        found = 1'b1;
      end
      base += dur;
    end
    v = IDLE_V;
    v[2] = 1'b1;
    case (p)
      0: begin v[13:7] = {3'd0, 2'd1, 2'd0}; v[6] = last; end
      1: begin v[13:7] = {3'd1, 2'd2, 2'd1}; v[6] = last; end
      2: v[5] = 1'b1;
      3: begin v[13:7] = {3'd2, 2'd0, 2'd2}; v[6] = last; end
      4: begin v[13:7] = {3'd3, 2'd1, 2'd1}; v[6] = last; end
      5: begin v[13:7] = {3'd4, 2'd2, 2'd1}; v[6] = last; end
      default: begin v[4] = 1'b1; v[3] = 1'b1; v[1] = 1'b1; end
    endcase
    return v;
  endfunction

  task automatic step(input logic r, input logic s, input logic c);
    logic [13:0] nxt[2];
    int lat;
    reset = r;
    start = s;
    ovr_clr = c;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 0 : 2;
      if (r) begin
        plen[i] = 0;
        pidx[i] = 0;
        ovr[i] = 1'b0;
        nxt[i] = IDLE_V;
      end else begin
        if (!cur[i][2] && s) begin
          plen[i] = 7 + 5 * lat;
          pidx[i] = 0;
          for (int k = 0; k < plen[i]; k++) pend[i][k] = run_vec(lat, k);
        end
        if (cur[i][2] && s) ovr[i] = OVR_EN;
        else if (c) ovr[i] = 1'b0;
        if (pidx[i] < plen[i]) begin
          nxt[i] = pend[i][pidx[i]];
          pidx[i]++;
        end else begin
          nxt[i] = IDLE_V;
        end
        nxt[i][0] = ovr[i];
      end
    end
    @(posedge clk);
    cur[0] = nxt[0];
    cur[1] = nxt[1];
    expq0.push_back(nxt[0]);
    expq1.push_back(nxt[1]);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // monitor: every cycle the DUTs present outputs, compare against the queued expectation
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq0.size() > 0) begin
        e = expq0.pop_front();
        checks++;
        if (act0 !== e) begin
          errors++;
          $display("FAIL lat0_outputs cycle %0d actual=%h expected=%h", cyc, act0, e);
        end
      end
      if (expq1.size() > 0) begin
        e = expq1.pop_front();
        checks++;
        if (act1 !== e) begin
          errors++;
          $display("FAIL lat2_outputs cycle %0d actual=%h expected=%h", cyc, act1, e);
        end
      end
    end
  end

  initial begin
    cur[0] = IDLE_V;
    cur[1] = IDLE_V;
    plen[0] = 0; plen[1] = 0;
    pidx[0] = 0; pidx[1] = 0;
    ovr[0] = 1'b0; ovr[1] = 1'b0;

    // reset held, with a start that must be dropped
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);

    // single sample, both latencies
    step(1'b0, 1'b1, 1'b0);
    idle(19);

    // start while busy, then clear racing a second busy start, then clear alone
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    idle(18);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // reset in the middle of a run
    step(1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    idle(20);

    // back-to-back accepted sample right after done
    step(1'b0, 1'b1, 1'b0);
    idle(7);
    step(1'b0, 1'b1, 1'b0);
    idle(20);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
